// File: rtl/shadow_pkg.sv
// Shared Shadow definitions: permutation modes, transposer FSM states and the
// row-index mapping between bundle order and DWchunk order.
package shadow_pkg;

    typedef enum logic [1:0] {
        MODE_NAT = 2'd0,
        MODE_B2C = 2'd1,
        MODE_C2B = 2'd2,
        MODE_RSV = 2'd3
    } mode_t;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Source row index for output word j; reserved mode falls back to natural order.
    function automatic int perm_index(input int nb, input int nr, input mode_t mode, input int j);
        case (mode)
            MODE_B2C: return nr * (j % nb) + j / nb;
            MODE_C2B: return nb * (j % nr) + j / nr;
            default:  return j;
        endcase
    endfunction

endpackage

// File: rtl/shadow_perm_idx.sv
// Maps (mode, output index) to the buffer row to read; pure combinational lookup.
// Tables are elaborated per parameter set, so no divider is built.
module shadow_perm_idx
    import shadow_pkg::*;
#(
    parameter int NB = 4,
    parameter int NR = 4,
    localparam int N  = NB * NR,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  mode_t          mode_i,
    input  logic [CW-1:0]  rcnt_i,
    output logic [CW-1:0]  idx_o
);

    logic [CW-1:0] tbl_b2c [N];
    logic [CW-1:0] tbl_c2b [N];

    for (genvar j = 0; j < N; j++) begin : g_tbl
        assign tbl_b2c[j] = CW'(perm_index(NB, NR, MODE_B2C, j));
        assign tbl_c2b[j] = CW'(perm_index(NB, NR, MODE_C2B, j));
    end

    always_comb begin
        idx_o = rcnt_i;
        case (mode_i)
            MODE_B2C: idx_o = tbl_b2c[rcnt_i];
            MODE_C2B: idx_o = tbl_c2b[rcnt_i];
            default:  idx_o = rcnt_i;
        endcase
    end

endmodule

// File: rtl/shadow_transposer.sv
// Buffers one N-row Shadow state, then re-emits it in natural, B2C or C2B order.
// Single buffer: a frame is fully loaded before draining, and drained before the next load.
module shadow_transposer
    import shadow_pkg::*;
#(
    parameter int NB = 4,
    parameter int NR = 4,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last
);

    localparam int N  = NB * NR;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    mode_t         mode_q, mode_d;
    logic [W-1:0]  mem_q [N];
    logic [CW-1:0] rd_idx;
    logic          in_fire;
    logic          out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            mode_q  <= MODE_NAT;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            mode_q  <= mode_d;
        end
    end

    // Frame storage carries no reset; contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_q[wcnt_q] <= in_data;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_LOAD: begin
                if (in_fire) begin
                    if (wcnt_q == '0) begin
                        mode_d = mode_t'(in_mode);
                    end
                    if (wcnt_q == LAST) begin
                        wcnt_d  = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        wcnt_d = wcnt_q + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (out_fire) begin
                    if (rcnt_q == LAST) begin
                        rcnt_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        rcnt_d = rcnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    shadow_perm_idx #(
        .NB (NB),
        .NR (NR)
    ) u_perm_idx (
        .mode_i (mode_q),
        .rcnt_i (rcnt_q),
        .idx_o  (rd_idx)
    );

    // Bus is zeroed outside DRAIN so no stale share data leaks onto it.
    always_comb begin
        in_ready  = (state_q == ST_LOAD);
        out_valid = (state_q == ST_DRAIN);
        out_data  = '0;
        out_last  = 1'b0;
        if (state_q == ST_DRAIN) begin
            out_data = mem_q[rd_idx];
            out_last = (rcnt_q == LAST);
        end
    end

endmodule

// File: tb/tb_shadow_transposer.sv
// Directed bench for shadow_transposer: a 4x4 instance and a 2x4 instance share stimulus.
module tb_shadow_transposer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_a, in_valid_b;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_last;
    logic [31:0] a_out_data;
    logic        b_in_ready, b_out_valid, b_out_last;
    logic [31:0] b_out_data;

    logic        sel;
    logic        cur_in_ready, cur_out_valid, cur_out_last;
    logic [31:0] cur_out_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    shadow_transposer #(.NB(4), .NR(4), .W(32)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_a),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_data  (a_out_data),
        .out_last  (a_out_last)
    );

    shadow_transposer #(.NB(2), .NR(4), .W(32)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_b),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_data  (b_out_data),
        .out_last  (b_out_last)
    );

    assign cur_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign cur_out_valid = sel ? b_out_valid : a_out_valid;
    assign cur_out_data  = sel ? b_out_data  : a_out_data;
    assign cur_out_last  = sel ? b_out_last  : a_out_last;

    typedef struct {
        bit         sel;
        logic [1:0] mode;
        int         n;
        bit         stall;
        int         exp[16];
    } vec_t;

    vec_t vecs[8];
    int   seq[16];
    int   b2c44[16];
    int   nat16[16];
    int   b2c24[16];
    int   exp_tmp[16];
    int   dat_tmp[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Presents n words back-to-back; in_mode switches to m2 from word chg_at onward.
    task automatic load_frame(input bit s, input int n, input logic [1:0] m, input int d[16],
                              input int chg_at, input logic [1:0] m2, input bit check_lat);
        sel = s;
        for (int k = 0; k < n; k++) begin
            in_valid_a = !s;
            in_valid_b = s;
            in_data    = d[k];
            in_mode    = (k >= chg_at) ? m2 : m;
            chk("load_in_ready", cur_in_ready, 1);
            chk("load_out_valid", cur_out_valid, 0);
            @(posedge clk); #1;
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_data    = '0;
        if (check_lat) chk("latency_out_valid", cur_out_valid, 1);
    endtask

    task automatic drain(input bit s, input int n, input int e[16], input bit stall);
        int  j    = 0;
        int  cyc  = 0;
        int  held = 0;
        bit  rdy;
        sel = s;
        while (j < n && cyc < 400) begin
            if (stall && j == 7 && held < 5) begin
                rdy = 1'b0;
                held++;
            end else if (stall) begin
                rdy = ($urandom_range(0, 2) != 0);
            end else begin
                rdy = 1'b1;
            end
            out_ready = rdy;
            chk("drain_out_valid", cur_out_valid, 1);
            chk("drain_in_ready", cur_in_ready, 0);
            chk("drain_out_data", cur_out_data, e[j]);
            chk("drain_out_last", cur_out_last, (j == n - 1));
            @(posedge clk); #1;
            if (rdy) j++;
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_word_count", j, n);
        chk("post_drain_out_valid", cur_out_valid, 0);
        chk("post_drain_out_data", cur_out_data, 0);
        chk("post_drain_in_ready", cur_in_ready, 1);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_data    = '0;
        in_mode    = 2'd0;
        out_ready  = 1'b0;
        sel        = 1'b0;

        for (int k = 0; k < 16; k++) begin
            seq[k]   = k;
            nat16[k] = k;
            b2c24[k] = 0;
        end
        b2c44 = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
        b2c24[0:7] = '{0, 4, 1, 5, 2, 6, 3, 7};

        vecs[0].sel = 0; vecs[0].mode = 2'd1; vecs[0].n = 16; vecs[0].stall = 0; vecs[0].exp = b2c44;
        vecs[1].sel = 0; vecs[1].mode = 2'd0; vecs[1].n = 16; vecs[1].stall = 0; vecs[1].exp = nat16;
        vecs[2].sel = 0; vecs[2].mode = 2'd3; vecs[2].n = 16; vecs[2].stall = 0; vecs[2].exp = nat16;
        vecs[3].sel = 0; vecs[3].mode = 2'd2; vecs[3].n = 16; vecs[3].stall = 0; vecs[3].exp = b2c44;
        vecs[4].sel = 1; vecs[4].mode = 2'd1; vecs[4].n = 8;  vecs[4].stall = 0;
        vecs[4].exp = '{0, 4, 1, 5, 2, 6, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5].sel = 1; vecs[5].mode = 2'd2; vecs[5].n = 8;  vecs[5].stall = 0;
        vecs[5].exp = '{0, 2, 4, 6, 1, 3, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[6].sel = 1; vecs[6].mode = 2'd0; vecs[6].n = 8;  vecs[6].stall = 0;
        vecs[6].exp = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[7].sel = 0; vecs[7].mode = 2'd1; vecs[7].n = 16; vecs[7].stall = 1; vecs[7].exp = b2c44;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        sel = 1'b0;
        chk("reset_a_in_ready", cur_in_ready, 1);
        chk("reset_a_out_valid", cur_out_valid, 0);
        chk("reset_a_out_data", cur_out_data, 0);
        chk("reset_a_out_last", cur_out_last, 0);
        sel = 1'b1;
        chk("reset_b_in_ready", cur_in_ready, 1);
        chk("reset_b_out_valid", cur_out_valid, 0);

        for (int v = 0; v < 8; v++) begin
            load_frame(vecs[v].sel, vecs[v].n, vecs[v].mode, seq, 99, 2'd0, 1'b1);
            drain(vecs[v].sel, vecs[v].n, vecs[v].exp, vecs[v].stall);
        end

        // Round trip on the 2x4 instance: B2C output fed back through C2B.
        load_frame(1'b1, 8, 2'd2, b2c24, 99, 2'd0, 1'b1);
        drain(1'b1, 8, seq, 1'b0);

        // in_mode changes mid-frame; the frame keeps the mode sampled on word 0.
        load_frame(1'b0, 16, 2'd1, seq, 5, 2'd0, 1'b1);
        drain(1'b0, 16, b2c44, 1'b0);

        // Reset after 9 of 16 words; only the fresh frame may come out.
        for (int k = 0; k < 16; k++) dat_tmp[k] = 200 + k;
        load_frame(1'b0, 9, 2'd2, dat_tmp, 99, 2'd2, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_load_in_ready", cur_in_ready, 1);
        chk("rst_load_out_valid", cur_out_valid, 0);
        for (int k = 0; k < 16; k++) begin
            dat_tmp[k] = 100 + k;
            exp_tmp[k] = 100 + b2c44[k];
        end
        load_frame(1'b0, 16, 2'd1, dat_tmp, 99, 2'd1, 1'b1);
        drain(1'b0, 16, exp_tmp, 1'b0);

        // Reset while word 3 is being presented in DRAIN.
        load_frame(1'b0, 16, 2'd1, seq, 99, 2'd1, 1'b1);
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk("rst_drain_pre_data", cur_out_data, b2c44[j]);
            @(posedge clk); #1;
        end
        chk("rst_drain_word3", cur_out_data, b2c44[3]);
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_drain_out_valid", cur_out_valid, 0);
        chk("rst_drain_out_data", cur_out_data, 0);
        chk("rst_drain_out_last", cur_out_last, 0);
        chk("rst_drain_in_ready", cur_in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_drain_idle_valid", cur_out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
